// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the parametrised VGA raster timing generator.
// The mode records let a top level choose a standard timing with a single constant.
package vga_timing_pkg;

    typedef struct packed {
        int   h_active;
        int   h_fp;
        int   h_sync;
        int   h_bp;
        int   v_active;
        int   v_fp;
        int   v_sync;
        int   v_bp;
        logic hs_pol;
        logic vs_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_640x480_60 = '{h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
                                               v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33,
                                               hs_pol: 1'b0, vs_pol: 1'b0};
    localparam vga_mode_t MODE_800x600_60 = '{h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
                                               v_active: 600, v_fp: 1, v_sync: 4, v_bp: 23,
                                               hs_pol: 1'b1, vs_pol: 1'b1};
    localparam vga_mode_t MODE_1024x768_60 = '{h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
                                                v_active: 768, v_fp: 3, v_sync: 6, v_bp: 29,
                                                hs_pol: 1'b0, vs_pol: 1'b0};

    // All-zero is the inactive decode, so flushing a stage means clearing it.
    typedef struct packed {
        logic de;
        logic hs_act;
        logic vs_act;
        logic ls;
        logic fs;
    } vga_decode_t;

    localparam int DECODE_W = $bits(vga_decode_t);

    // Bits needed for a counter that runs 0 .. total-1.
    function automatic int count_width(input int total);
        return (total <= 1) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-domain bundle between the timing generator and the readout/colour pipeline.
interface vga_timing_gen_if #(
    parameter int X_W = 11,
    parameter int Y_W = 10
);
    logic           ce;
    logic [X_W-1:0] countX;
    logic [Y_W-1:0] countY;
    logic           HS;
    logic           VS;
    logic           DE;
    logic           line_start;
    logic           frame_start;

    modport master (
        input  ce,
        output countX, countY, HS, VS, DE, line_start, frame_start
    );

    modport slave (
        output ce,
        input  countX, countY, HS, VS, DE, line_start, frame_start
    );
endinterface

// File: rtl/vga_delay_line.sv
// Pixel-enable qualified shift register; DEPTH=0 degenerates to a plain wire.
module vga_delay_line #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, ce};
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
                end else if (ce) begin
                    stages[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: position counters, registered sync/DE decode,
// an optional alignment delay and single-clock line/frame strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = MODE_1024x768_60.h_active,
    parameter int H_FP     = MODE_1024x768_60.h_fp,
    parameter int H_SYNC   = MODE_1024x768_60.h_sync,
    parameter int H_BP     = MODE_1024x768_60.h_bp,
    parameter int V_ACTIVE = MODE_1024x768_60.v_active,
    parameter int V_FP     = MODE_1024x768_60.v_fp,
    parameter int V_SYNC   = MODE_1024x768_60.v_sync,
    parameter int V_BP     = MODE_1024x768_60.v_bp,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int X_W      = 11,
    parameter int Y_W      = 10,
    parameter int PIPE_DLY = 0
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
            $fatal(1, "vga_timing_gen: every timing field must be at least 1");
        end
        if (X_W < count_width(H_TOTAL) || Y_W < count_width(V_TOTAL)) begin : g_bad_width
            $fatal(1, "vga_timing_gen: X_W/Y_W too narrow for the raster totals");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_bad_delay
            $fatal(1, "vga_timing_gen: PIPE_DLY must lie in 0..15");
        end
    endgenerate

    localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] X_ACTIVE = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_BEGIN = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_ACTIVE = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_BEGIN = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic           HS_ON    = 1'(HS_POL);
    localparam logic           VS_ON    = 1'(VS_POL);

    logic [X_W-1:0] countX;
    logic [Y_W-1:0] countY;
    vga_decode_t    decNow;
    vga_decode_t    decReg;
    vga_decode_t    decOut;
    logic           loadedLast;

    always_comb begin
        decNow        = '0;
        decNow.de     = (countX < X_ACTIVE) && (countY < Y_ACTIVE);
        decNow.hs_act = (countX >= HS_BEGIN) && (countX < HS_END);
        decNow.vs_act = (countY >= VS_BEGIN) && (countY < VS_END);
        decNow.ls     = (countX == '0);
        decNow.fs     = (countX == '0) && (countY == '0);
    end

    // loadedLast marks the clk right after a ce edge; it gates the strobes to one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            countX     <= '0;
            countY     <= '0;
            decReg     <= '0;
            loadedLast <= 1'b0;
        end else begin
            loadedLast <= vga.ce;
            if (vga.ce) begin
                decReg <= decNow;
                if (countX == X_LAST) begin
                    countX <= '0;
                    countY <= (countY == Y_LAST) ? '0 : countY + Y_W'(1);
                end else begin
                    countX <= countX + X_W'(1);
                end
            end
        end
    end

    vga_delay_line #(
        .WIDTH(DECODE_W),
        .DEPTH(PIPE_DLY)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .ce  (vga.ce),
        .din (decReg),
        .dout(decOut)
    );

    assign vga.countX      = countX;
    assign vga.countY      = countY;
    assign vga.HS          = decOut.hs_act ? HS_ON : ~HS_ON;
    assign vga.VS          = decOut.vs_act ? VS_ON : ~VS_ON;
    assign vga.DE          = decOut.de;
    assign vga.line_start  = decOut.ls & loadedLast;
    assign vga.frame_start = decOut.fs & loadedLast;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two small rasters (no delay, delay 3) and the
// default 1024x768 raster with a delay of 4, all checked against a raster model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
    } obs_t;

    logic clk;
    logic rst;
    logic rst_c;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int tAB = 0;
    int tC  = 0;
    obs_t qa[$];
    obs_t qb[$];
    obs_t qc[$];

    // Measurement results gathered by the directed phases.
    int lsCount, fsCount, fsFirst, fsSecond, lsBadGap, fsAlone, lsDouble;
    int hsLow, vsLow, deHigh, hsRuns;
    int c1024 = -1, c1048 = -1, c1184 = -1, cHsOn = -1, cHsOff = -1, cDeFall = -1;
    logic prevDeC = 1'b0;

    vga_timing_gen_if #(.X_W(11), .Y_W(10)) ifa ();
    vga_timing_gen_if #(.X_W(11), .Y_W(10)) ifb ();
    vga_timing_gen_if #(.X_W(11), .Y_W(10)) ifc ();

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .X_W(11), .Y_W(10), .PIPE_DLY(0)
    ) dut_a (.clk(clk), .rst(rst), .vga(ifa));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .X_W(11), .Y_W(10), .PIPE_DLY(3)
    ) dut_b (.clk(clk), .rst(rst), .vga(ifb));

    vga_timing_gen #(
        .H_ACTIVE(1024), .H_FP(24), .H_SYNC(136), .H_BP(160),
        .V_ACTIVE(768), .V_FP(3), .V_SYNC(6), .V_BP(29),
        .HS_POL(0), .VS_POL(0), .X_W(11), .Y_W(10), .PIPE_DLY(4)
    ) dut_c (.clk(clk), .rst(rst_c), .vga(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raster model: t counts pixel ticks since reset; outputs show the pixel 1+d ticks back.
    function automatic obs_t model(input int t, input bit fresh,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input int d);
        obs_t m;
        int htot, vtot, lag, lx, ly;
        htot = ha + hf + hsw + hb;
        vtot = va + vf + vsw + vb;
        m    = '0;
        m.x  = 11'(t % htot);
        m.y  = 10'((t / htot) % vtot);
        m.hs = 1'b1;
        m.vs = 1'b1;
        lag  = t - 1 - d;
        if (lag >= 0) begin
            lx   = lag % htot;
            ly   = (lag / htot) % vtot;
            m.de = (lx < ha) && (ly < va);
            m.hs = !((lx >= ha + hf) && (lx < ha + hf + hsw));
            m.vs = !((ly >= va + vf) && (ly < va + vf + vsw));
            m.ls = fresh && (lx == 0);
            m.fs = fresh && (lx == 0) && (ly == 0);
        end
        return m;
    endfunction

    function automatic obs_t sampleA();
        return obs_t'({ifa.countX, ifa.countY, ifa.HS, ifa.VS, ifa.DE, ifa.line_start, ifa.frame_start});
    endfunction
    function automatic obs_t sampleB();
        return obs_t'({ifb.countX, ifb.countY, ifb.HS, ifb.VS, ifb.DE, ifb.line_start, ifb.frame_start});
    endfunction
    function automatic obs_t sampleC();
        return obs_t'({ifc.countX, ifc.countY, ifc.HS, ifc.VS, ifc.DE, ifc.line_start, ifc.frame_start});
    endfunction

    task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d actual x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b required x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                     name, cyc, act.x, act.y, act.hs, act.vs, act.de, act.ls, act.fs,
                     exp.x, exp.y, exp.hs, exp.vs, exp.de, exp.ls, exp.fs);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs at negedge, queue the expected response, sample after posedge.
    task automatic applyStimulus(input bit r, input bit c);
        @(negedge clk);
        rst    = r;
        ifa.ce = c;
        ifb.ce = c;
        rst_c  = (cyc < 2);
        ifc.ce = 1'b1;
        if (r) tAB = 0;
        else if (c) tAB++;
        if (rst_c) tC = 0;
        else tC++;
        qa.push_back(model(tAB, c && !r, 8, 2, 3, 1, 4, 1, 2, 1, 0));
        qb.push_back(model(tAB, c && !r, 8, 2, 3, 1, 4, 1, 2, 1, 3));
        qc.push_back(model(tC, !rst_c, 1024, 24, 136, 160, 768, 3, 6, 29, 4));
        @(posedge clk);
        #2;
        if (ifc.countY == 10'd0 && ifc.countX == 11'd1024 && c1024 < 0) c1024 = cyc;
        if (ifc.countY == 10'd0 && ifc.countX == 11'd1048 && c1048 < 0) c1048 = cyc;
        if (ifc.countY == 10'd0 && ifc.countX == 11'd1184 && c1184 < 0) c1184 = cyc;
        if (ifc.HS == 1'b0 && cHsOn < 0) cHsOn = cyc;
        if (ifc.HS == 1'b1 && cHsOn >= 0 && cHsOff < 0) cHsOff = cyc;
        if (ifc.DE == 1'b0 && prevDeC && cDeFall < 0) cDeFall = cyc;
        prevDeC = ifc.DE;
        cyc++;
    endtask

    // Reset, then run n clks with one ce tick every cePeriod clks, collecting raster statistics.
    task automatic measure(input int n, input int cePeriod);
        logic prevLs, prevHs;
        int lastLs;
        applyStimulus(1'b1, 1'b0);
        lsCount = 0; fsCount = 0; fsFirst = -1; fsSecond = -1; lsBadGap = 0; fsAlone = 0;
        lsDouble = 0; hsLow = 0; vsLow = 0; deHigh = 0; hsRuns = 0;
        lastLs = -1; prevLs = 1'b0; prevHs = 1'b1;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, (i % cePeriod) == 0);
            if (ifa.line_start) begin
                lsCount++;
                if (lastLs >= 0 && i - lastLs != 14 * cePeriod) lsBadGap++;
                if (prevLs) lsDouble++;
                lastLs = i;
            end
            if (ifa.frame_start) begin
                fsCount++;
                if (!ifa.line_start) fsAlone++;
                if (fsFirst < 0) fsFirst = i;
                else if (fsSecond < 0) fsSecond = i;
            end
            if (!ifa.HS) hsLow++;
            if (!ifa.VS) vsLow++;
            if (ifa.DE) deHigh++;
            if (!ifa.HS && prevHs) hsRuns++;
            prevLs = ifa.line_start;
            prevHs = ifa.HS;
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #2;
            if (qa.size() > 0) checkOutput("dutA_raster", sampleA(), qa.pop_front());
            if (qb.size() > 0) checkOutput("dutB_raster", sampleB(), qb.pop_front());
            if (qc.size() > 0) checkOutput("dutC_raster", sampleC(), qc.pop_front());
        end
    end

    initial begin : stimulus
        int found;
        rst    = 1'b1;
        rst_c  = 1'b1;
        ifa.ce = 1'b0;
        ifb.ce = 1'b0;
        ifc.ce = 1'b0;

        applyStimulus(1'b1, 1'b0);
        checkOutput("reset_state", sampleA(), obs_t'({11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));

        $display("[TB] free-run two frames, ce=1");
        measure(224, 1);
        checkValue("p1_line_starts", lsCount, 16);
        checkValue("p1_line_gap", lsBadGap, 0);
        checkValue("p1_frame_starts", fsCount, 2);
        checkValue("p1_frame_period", fsSecond - fsFirst, 112);
        checkValue("p1_fs_without_ls", fsAlone, 0);
        checkValue("p1_hs_clks", hsLow, 48);
        checkValue("p1_hs_pulses", hsRuns, 16);
        checkValue("p1_vs_clks", vsLow, 56);
        checkValue("p1_de_clks", deHigh, 64);

        $display("[TB] ce pattern 1,0,0");
        measure(672, 3);
        checkValue("p2_line_starts", lsCount, 16);
        checkValue("p2_line_gap", lsBadGap, 0);
        checkValue("p2_strobe_width", lsDouble, 0);
        checkValue("p2_frame_period", fsSecond - fsFirst, 336);
        checkValue("p2_hs_clks", hsLow, 144);
        checkValue("p2_hs_pulses", hsRuns, 16);

        $display("[TB] random ce with sporadic reset");
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 1500; i++)
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);

        $display("[TB] mid-frame reset");
        applyStimulus(1'b1, 1'b0);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            applyStimulus(1'b0, 1'b1);
            if (ifa.countX == 11'd5 && ifa.countY == 10'd2) found = 1;
        end
        checkValue("p6_reached_position", found, 1);
        if (found == 1) begin
            checkValue("p6_vs_inactive_before", int'(ifa.VS), 1);
            applyStimulus(1'b1, 1'b1);
            checkOutput("p6_after_reset", sampleA(), obs_t'({11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
            applyStimulus(1'b0, 1'b1);
            checkOutput("p6_resume", sampleA(), obs_t'({11'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}));
        end

        checkValue("p5_hs_assert_lag", cHsOn - c1048, 5);
        checkValue("p5_hs_deassert_lag", cHsOff - c1184, 5);
        checkValue("p5_de_fall_lag", cDeFall - c1024, 5);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the team's fixed 1024x768@60 Hz controller. Every horizontal and vertical timing field, both sync polarities and the counter widths are parameters. It adds a pixel clock-enable, a data-enable (DE) output, line-start and frame-start strobes, and a configurable output delay that aligns sync and DE with a downstream pixel pipeline. It sits between the pixel-clock domain and the frame-buffer readout/colour pipeline.

## Interface
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- HS_POL, 0, asserted level of HS (0 = active-low)
- VS_POL, 0, asserted level of VS
- X_W, 11, countX width; must hold H_TOTAL-1
- Y_W, 10, countY width; must hold V_TOTAL-1
- PIPE_DLY, 0, extra output delay of HS/VS/DE/strobes in ce ticks (0..15)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  pixel enable; the raster advances only on cycles with ce=1
- countX  out  X_W  current horizontal position (undelayed)
- countY  out  Y_W  current vertical position (undelayed)
- HS  out  1  horizontal sync, polarity per HS_POL
- VS  out  1  vertical sync, polarity per VS_POL
- DE  out  1  high while the delayed position is inside the active area
- line_start  out  1  one-clk strobe at delayed x==0 on every line (active and blanking lines)
- frame_start  out  1  one-clk strobe at delayed (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters: on clk with ce=1, countX increments. At countX==H_TOTAL-1 it wraps to 0 and countY increments. countY wraps to 0 at V_TOTAL-1 when countX also wraps. With ce=0, all state holds, including the delay line.
- Decode of position (x,y):
  - de = x<H_ACTIVE && y<V_ACTIVE
  - hs_act = H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC
  - vs_act = V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (whole lines, changes at x wrap)
  - ls = x==0; fs = x==0 && y==0
- Output path: the decode is registered on ce, then passes through PIPE_DLY further ce-qualified stages. HS = hs_act ? HS_POL : ~HS_POL; VS likewise.
- Strobes: line_start/frame_start are high only in the single clk cycle immediately following the ce edge that loads an ls/fs-true value into the final stage. They drop the next clk even if ce=0.
- Elaboration checks: fatal error if any timing parameter <1, if X_W/Y_W are too narrow, or if PIPE_DLY>15.

## Timing
- Reset (rst=1 at clk edge, overrides ce): countX=0, countY=0, HS=~HS_POL, VS=~VS_POL, DE=0, line_start=0, frame_start=0. All delay stages are flushed to the inactive decode.
- Latency: HS/VS/DE/strobes reflect the counter value from 1+PIPE_DLY ce ticks earlier. With ce tied high, that is 1+PIPE_DLY clks.
- After reset release with ce=1 and PIPE_DLY=0, the first edge gives countX=1 and DE=line_start=frame_start=1.
- Reset mid-frame takes effect on the same edge: counters return to (0,0) and outputs go inactive immediately, not after the delay.
- ce=0 for one or more cycles inserts no extra pixels and no duplicated strobes.
- Simultaneous x and y wrap occurs on a single edge; no intermediate (0, V_TOTAL) state is visible.

## Structure
- Package vga_timing_pkg: mode record typedef (8 timing fields plus polarities) and constants MODE_640x480_60, MODE_800x600_60, MODE_1024x768_60. It also holds a clog2-based width helper for X_W/Y_W.
- Sub-module vga_delay_line: ce-qualified shift register with parameters WIDTH and DEPTH (DEPTH=0 is a wire). It carries {de, hs_act, vs_act, ls, fs}.

## Test plan
Scenarios 1–4 use small parameters: H 8/2/3/1 (H_TOTAL 14), V 4/1/2/1 (V_TOTAL 8), PIPE_DLY=0, ce=1.
1. Reset, then free-run 2 frames:
   - countX sequence 0..13 wraps.
   - countY wraps 7→0 on the same edge as x 13→0.
   - Frame period is 112 clks.
2. Same run, output decode:
   - HS asserted (0) for exactly 3 clks per line, when lagged x=10..12.
   - VS asserted for lines 5–6 (28 clks).
   - DE high 8 clks on each of lines 0–3 and low on lines 4–7.
3. Strobes: line_start fires 8 times per frame, 14 clks apart. frame_start fires once per 112 clks, coincident with a line_start.
4. ce pattern 1,0,0 (one tick per 3 clks): frame period is 336 clks, each strobe is 1 clk wide, and the HS pulse lasts 3 ticks (9 clks).
5. PIPE_DLY=4 with default 1024x768: HS asserts 5 clks after countX==1048, deasserts 5 clks after countX==1184, and DE falls 5 clks after countX==1024.
6. Assert rst for 1 clk at countX=500, countY=300 while VS is inactive: the next cycle shows (0,0), HS/VS inactive, DE=0, and no strobe. Normal sequence resumes on the following edge.
